// File: rtl/risc_control_unit_pkg.sv
// Shared encodings for the RISC control unit: ISA opcodes, FSM states,
// datapath mux selects and instruction field positions.
package risc_control_unit_pkg;

  localparam int word_size  = 8;
  localparam int op_size    = 4;
  localparam int Sel1_size  = 3;
  localparam int Sel2_size  = 2;
  localparam int state_size = 4;
  localparam int REG_W      = 2;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int SRC_MSB = 3;
  localparam int SRC_LSB = 2;
  localparam int DST_MSB = 1;
  localparam int DST_LSB = 0;

  localparam logic [op_size-1:0] OP_NOP = 4'd0;
  localparam logic [op_size-1:0] OP_ADD = 4'd1;
  localparam logic [op_size-1:0] OP_SUB = 4'd2;
  localparam logic [op_size-1:0] OP_AND = 4'd3;
  localparam logic [op_size-1:0] OP_NOT = 4'd4;
  localparam logic [op_size-1:0] OP_RD  = 4'd5;
  localparam logic [op_size-1:0] OP_WR  = 4'd6;
  localparam logic [op_size-1:0] OP_BR  = 4'd7;
  localparam logic [op_size-1:0] OP_BRZ = 4'd8;

  localparam logic [Sel1_size-1:0] SEL1_PC   = 3'd4;
  localparam logic [Sel2_size-1:0] SEL2_ALU  = 2'd0;
  localparam logic [Sel2_size-1:0] SEL2_BUS1 = 2'd1;
  localparam logic [Sel2_size-1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [state_size-1:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  // Register fields map onto Bus_1 selects 0..3 directly.
  function automatic logic [Sel1_size-1:0] sel1_reg(input logic [REG_W-1:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/risc_control_unit.sv
// Multi-cycle control FSM for the 8-bit Processing_Unit datapath: sequences
// fetch, decode, execute, memory and branch, driving every datapath strobe.
module risc_control_unit
  import risc_control_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 Zflag,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic                 write
);

  state_t               state_q, state_d;
  logic [op_size-1:0]   opcode;
  logic [REG_W-1:0]     src;
  logic [REG_W-1:0]     dest;
  logic [3:0]           load_r;

  assign opcode = instruction[OP_MSB:OP_LSB];
  assign src    = instruction[SRC_MSB:SRC_LSB];
  assign dest   = instruction[DST_MSB:DST_LSB];

  assign Load_R0 = load_r[0];
  assign Load_R1 = load_r[1];
  assign Load_R2 = load_r[2];
  assign Load_R3 = load_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_r        = '0;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = SEL2_ALU;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    write         = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FET1;

      S_FET1: begin
        Sel_Bus_1_Mux = SEL1_PC;
        Sel_Bus_2_Mux = SEL2_BUS1;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = S_FET2;
      end

      S_FET2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_IR       = 1'b1;
        state_d       = S_DEC;
      end

      S_DEC: begin
        case (opcode)
          OP_NOP: state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: begin
            Sel_Bus_1_Mux = sel1_reg(src);
            Sel_Bus_2_Mux = SEL2_BUS1;
            Load_Reg_Y    = 1'b1;
            state_d       = S_EX1;
          end
          OP_NOT: begin
            Sel_Bus_1_Mux = sel1_reg(src);
            Sel_Bus_2_Mux = SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            load_r[dest]  = 1'b1;
            state_d       = S_FET1;
          end
          // Two-byte instructions: point the address register at the operand byte.
          OP_RD, OP_WR, OP_BR: begin
            Sel_Bus_1_Mux = SEL1_PC;
            Sel_Bus_2_Mux = SEL2_BUS1;
            Load_Add_R    = 1'b1;
            state_d       = (opcode == OP_RD) ? S_RD1 :
                            (opcode == OP_WR) ? S_WR1 : S_BR1;
          end
          OP_BRZ: begin
            if (Zflag) begin
              Sel_Bus_1_Mux = SEL1_PC;
              Sel_Bus_2_Mux = SEL2_BUS1;
              Load_Add_R    = 1'b1;
              state_d       = S_BR1;
            end else begin
              Inc_PC  = 1'b1;
              state_d = S_FET1;
            end
          end
          default: state_d = S_HALT;
        endcase
      end

      S_EX1: begin
        Sel_Bus_1_Mux = sel1_reg(dest);
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_Reg_Z    = 1'b1;
        load_r[dest]  = 1'b1;
        state_d       = S_FET1;
      end

      S_RD1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = S_RD2;
      end

      S_RD2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        load_r[dest]  = 1'b1;
        state_d       = S_FET1;
      end

      S_WR1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = S_WR2;
      end

      S_WR2: begin
        Sel_Bus_1_Mux = sel1_reg(src);
        write         = 1'b1;
        state_d       = S_FET1;
      end

      S_BR1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        state_d       = S_BR2;
      end

      S_BR2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_PC       = 1'b1;
        state_d       = S_FET1;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: per-instruction strobe sequences are
// queued by the stimulus and compared cycle by cycle by an independent monitor.
module tb_risc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instruction;
  logic       Zflag;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write;

  risc_control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
    .Load_PC(Load_PC), .Inc_PC(Inc_PC),
    .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
    .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y),
    .Load_Reg_Z(Load_Reg_Z), .write(write)
  );

  always #5 clk = ~clk;

  typedef logic [15:0] vq_t[$];

  vq_t         exp_q;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] act_m, exp_m;

  // Packed view: {Load_R3..R0, Load_PC, Inc_PC, Sel1, Sel2, IR, AddR, RegY, RegZ, write}
  function automatic logic [15:0] v(input int r, input bit pc, input bit inc,
                                    input int s1, input int s2, input bit ir,
                                    input bit ad, input bit y, input bit z, input bit wr);
    logic [3:0] lr;
    lr = 4'b0000;
    if (r >= 0) lr[r[1:0]] = 1'b1;
    return {lr, pc, inc, 3'(s1), 2'(s2), ir, ad, y, z, wr};
  endfunction

  // Cycle-by-cycle strobe listing of one instruction, starting at the first fetch cycle.
  function automatic vq_t model(input logic [7:0] ins, input bit z);
    vq_t q;
    int op, src, dst;
    op  = int'(ins[7:4]);
    src = int'(ins[3:2]);
    dst = int'(ins[1:0]);
    q.push_back(v(-1, 0, 1, 4, 1, 0, 1, 0, 0, 0));
    q.push_back(v(-1, 0, 0, 0, 2, 1, 0, 0, 0, 0));
    if (op == 0) begin
      q.push_back(16'h0);
    end else if (op >= 1 && op <= 3) begin
      q.push_back(v(-1, 0, 0, src, 1, 0, 0, 1, 0, 0));
      q.push_back(v(dst, 0, 0, dst, 0, 0, 0, 0, 1, 0));
    end else if (op == 4) begin
      q.push_back(v(dst, 0, 0, src, 0, 0, 0, 0, 1, 0));
    end else if (op == 5) begin
      q.push_back(v(-1, 0, 0, 4, 1, 0, 1, 0, 0, 0));
      q.push_back(v(-1, 0, 1, 0, 2, 0, 1, 0, 0, 0));
      q.push_back(v(dst, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    end else if (op == 6) begin
      q.push_back(v(-1, 0, 0, 4, 1, 0, 1, 0, 0, 0));
      q.push_back(v(-1, 0, 1, 0, 2, 0, 1, 0, 0, 0));
      q.push_back(v(-1, 0, 0, src, 0, 0, 0, 0, 0, 1));
    end else if (op == 7 || (op == 8 && z)) begin
      q.push_back(v(-1, 0, 0, 4, 1, 0, 1, 0, 0, 0));
      q.push_back(v(-1, 0, 0, 0, 2, 0, 1, 0, 0, 0));
      q.push_back(v(-1, 1, 0, 0, 2, 0, 0, 0, 0, 0));
    end else if (op == 8) begin
      q.push_back(v(-1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      q.push_back(16'h0);
    end
    return q;
  endfunction

  task automatic drive_cycle(input logic [15:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] ins, input bit z);
    vq_t seq;
    instruction = ins;
    Zflag       = z;
    seq         = model(ins, z);
    foreach (seq[i]) drive_cycle(seq[i]);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    drive_cycle(16'h0);
    rst = 1'b1;
    drive_cycle(16'h0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_m = exp_q.pop_front();
      act_m = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC,
               Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
               Load_Reg_Y, Load_Reg_Z, write};
      vectors++;
      if (act_m !== exp_m) begin
        miscompares++;
        $display("FAIL strobes vec#%0d t=%0t instr=%h Z=%b actual=%h required=%h",
                 vectors, $time, instruction, Zflag, act_m, exp_m);
      end
      if (!$onehot0({Load_R3, Load_R2, Load_R1, Load_R0}) || (Load_PC && Inc_PC)) begin
        miscompares++;
        $display("FAIL exclusivity vec#%0d actual=%b required=onehot0,no PC+Inc",
                 vectors, {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC});
      end
    end
  end

  initial begin
    logic [7:0] ins;
    rst         = 1'b0;
    instruction = 8'h00;
    Zflag       = 1'b0;
    @(posedge clk);
    #1;

    repeat (3) drive_cycle(16'h0);
    rst = 1'b1;
    drive_cycle(16'h0);

    // Reset dropped while the fetch is in progress.
    drive_cycle(v(-1, 0, 1, 4, 1, 0, 1, 0, 0, 0));
    rst = 1'b0;
    drive_cycle(16'h0);
    drive_cycle(16'h0);
    rst = 1'b1;
    drive_cycle(16'h0);

    run_instr(8'h1B, 1'b0);
    run_instr(8'h51, 1'b0);
    run_instr(8'h68, 1'b1);
    run_instr(8'h80, 1'b1);
    run_instr(8'h80, 1'b0);
    run_instr(8'h00, 1'b1);
    run_instr(8'h4E, 1'b0);
    run_instr(8'h70, 1'b0);

    repeat (150) begin
      ins = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
      run_instr(ins, 1'($urandom_range(0, 1)));
    end

    run_instr(8'hF0, 1'b0);
    repeat (25) begin
      instruction = 8'($urandom_range(0, 255));
      Zflag       = 1'($urandom_range(0, 1));
      drive_cycle(16'h0);
    end
    reset_pulse();
    run_instr(8'h00, 1'b0);

    repeat (4) begin
      ins = {4'($urandom_range(9, 15)), 4'($urandom_range(0, 15))};
      run_instr(ins, 1'($urandom_range(0, 1)));
      repeat (5) drive_cycle(16'h0);
      reset_pulse();
      run_instr(8'h2D, 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
- Multi-cycle control FSM that drives every load, increment and mux-select strobe of the 8-bit Processing_Unit datapath.
- Sits directly upstream of the datapath. Consumes the datapath's instruction register output and Zflag.
- Also drives the write strobe of the shared instruction/data memory.
- Sequences fetch, decode, execute, memory read/write and branch for a 9-opcode ISA.

Parameters:
- word_size, 8, instruction width
- op_size, 4, opcode field width, instruction[7:4]
- Sel1_size, 3, Bus_1 mux select width
- Sel2_size, 2, Bus_2 mux select width
- state_size, 4, state register width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instruction  in  8  IR contents: [7:4] opcode, [3:2] src, [1:0] dest
- Zflag  in  1  registered ALU zero flag
- Load_R0, Load_R1, Load_R2, Load_R3  out  1 each  register load enables
- Load_PC  out  1  PC load from Bus_2
- Inc_PC  out  1  PC increment
- Sel_Bus_1_Mux  out  3  0=R0, 1=R1, 2=R2, 3=R3, 4=PC
- Sel_Bus_2_Mux  out  2  0=ALU, 1=Bus_1, 2=mem_word
- Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  out  1 each  datapath register enables
- write  out  1  memory write strobe

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- State register: binary, updated on posedge clk. rst=0 forces state to S_idle immediately, including mid-instruction.
- Outputs: combinational from state, instruction and Zflag. Any signal not listed for a state is 0; both selects default to 0. In S_idle and S_halt every output is 0, so all outputs read 0 during reset.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Opcodes 9–15 are illegal.
- Two-byte instructions: RD, WR, BR, BRZ. The second byte is a memory address.
- S_idle -> S_fet1, with no outputs.
- S_fet1: Sel1=4, Sel2=1, Load_Add_R, Inc_PC. Next S_fet2.
- S_fet2: Sel2=2, Load_IR. Next S_dec.
- S_dec, by opcode:
  - NOP: next S_fet1, no outputs.
  - ADD/SUB/AND: Sel1=src, Sel2=1, Load_Reg_Y. Next S_ex1.
  - NOT: Sel1=src, Sel2=0, Load_Reg_Z, Load_R[dest]. Next S_fet1.
  - RD: Sel1=4, Sel2=1, Load_Add_R. Next S_rd1.
  - WR: Sel1=4, Sel2=1, Load_Add_R. Next S_wr1.
  - BR: Sel1=4, Sel2=1, Load_Add_R. Next S_br1.
  - BRZ, Zflag=1: same outputs as BR. Next S_br1.
  - BRZ, Zflag=0: Inc_PC only, skipping the address byte. Next S_fet1.
  - Illegal: no outputs. Next S_halt.
- S_ex1: Sel1=dest, Sel2=0, Load_Reg_Z, Load_R[dest]. Next S_fet1.
- S_rd1: Sel2=2, Load_Add_R, Inc_PC. Next S_rd2.
- S_rd2: Sel2=2, Load_R[dest]. Next S_fet1.
- S_wr1: Sel2=2, Load_Add_R, Inc_PC. Next S_wr2.
- S_wr2: Sel1=src, write. Next S_fet1.
- S_br1: Sel2=2, Load_Add_R. Next S_br2.
- S_br2: Sel2=2, Load_PC. Next S_fet1.
- S_halt: stays in S_halt until rst.
- Latency from S_fet1 entry to the next S_fet1:
  - NOP, NOT, BRZ not taken: 3 cycles
  - ALU op: 4 cycles
  - RD, WR, BR, BRZ taken: 5 cycles
- Strobe exclusivity: at most one Load_Rx is asserted per cycle. Load_PC and Inc_PC are never asserted together.
- Unused encodings (Sel1 5–7, Sel2 3, unused state codes) are never driven. An unreachable state recovers to S_idle.

Decomposition:
- Shared package holds:
  - opcode constants
  - state encodings
  - Sel1 and Sel2 select encodings
  - instruction field slice positions
- No sub-module. A single FSM with a next-state/output always block and a state register is sufficient.
- Instantiated alongside Processing_Unit in the top-level processor, port names matching one-to-one.

Test Plan:
1. Reset: hold rst=0 for 3 cycles, pulse it low mid-fetch -> all outputs 0; state is S_idle one cycle after release, then S_fet1 with Sel1=4, Sel2=1, Load_Add_R=1, Inc_PC=1.
2. ADD, instruction=0x1B (src=R2, dest=R3) -> S_dec: Sel1=2, Load_Reg_Y; S_ex1: Sel1=3, Sel2=0, Load_Reg_Z, Load_R3; back in S_fet1 4 cycles after the first fetch.
3. RD, instruction=0x51 (dest=R1) -> S_rd1: Inc_PC=1; S_rd2: Sel2=2, Load_R1=1; no other Load_Rx asserted.
4. WR, instruction=0x68 (src=R2) -> S_wr2: Sel1=2, write=1 for exactly 1 cycle.
5. BRZ, instruction=0x80 -> with Zflag=1: Load_PC in S_br2, 5-cycle instruction; with Zflag=0: only Inc_PC in S_dec, 3-cycle instruction.
6. Illegal opcode, instruction=0xF0 -> enters S_halt with all outputs 0 for 20+ cycles; recovers to S_fet1 only after rst pulse.
